column_frame_writer: RTL and testbench
======================================

// Module: column_frame_writer
// PURPOSE
// Configuration-side driver for one fabric column. It consumes a valid/ready word stream from the config port.
// It assembles a full frame of FrameData for the column and pulses exactly one FrameStrobe bit.
// It is the writer for the FrameStrobe/FrameData chain that the column tiles and terminator tiles consume.
// One instance per column, placed at the south edge; its FrameStrobe output feeds the column's bottom tile.
// PARAMETERS
// MaxFramesPerCol  20  frames per column; width of FrameStrobe
// FrameBitsPerRow  32  bits per row per frame; equals the cfg word width
// NumRows          4   tile rows in the column; data words per frame
// ColumnIndex      0   8-bit column address this instance answers to
// StrobeCycles     1   FrameStrobe pulse width in cycles (1..15)
// PORTS
// UserCLK        in   1                            clock; all logic on rising edge
// resetn         in   1                            synchronous active-low reset
// cfg_valid      in   1                            word on cfg_data valid
// cfg_ready      out  1                            block accepts the word this cycle
// cfg_data       in   FrameBitsPerRow              header or data word
// FrameData      out  NumRows*FrameBitsPerRow      assembled frame; row r = [r*FrameBitsPerRow +: FrameBitsPerRow]
// FrameStrobe    out  MaxFramesPerCol              one-hot frame write strobe
// busy           out  1                            high in any state except IDLE
// err_sync       out  1                            1-cycle pulse: bad header magic
// err_range      out  1                            1-cycle pulse: frame index >= MaxFramesPerCol
// frames_written out  16                           count of strobes issued; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset (resetn=0 at edge): state=IDLE; all outputs 0 except cfg_ready=1 after reset release.
//   Reset clears FrameData, FrameStrobe, the counter and the row index; a partially received frame is discarded.
// - Transfer occurs when cfg_valid && cfg_ready at the edge. cfg_ready is combinational from state: 1 in IDLE/DATA, 0 in STROBE.
// - Header word format:
//   - [31:24] = 8'hFA (magic)
//   - [23:16] = column address
//   - [7:0]   = frame index
//   - other bits are ignored
// - IDLE: on transfer, the header is checked.
//   - Bad magic: the word is dropped, err_sync pulses next cycle, state stays IDLE.
//   - Good magic: latch match = (col == ColumnIndex), latch frame index, set row=0, go to DATA.
// - DATA: each transfer writes cfg_data to FrameData row `row` when match=1; FrameData is unchanged when match=0. row increments.
//   - On the transfer with row == NumRows-1:
//     - match=1 and idx < MaxFramesPerCol: go to STROBE.
//     - match=1 and idx >= MaxFramesPerCol: err_range pulses next cycle, go to IDLE.
//     - match=0: go to IDLE with no error.
// - STROBE: FrameStrobe[idx]=1 for exactly StrobeCycles cycles, starting the cycle after the last data word.
//   - FrameData is held stable throughout.
//   - frames_written increments once, on entry to STROBE.
//   - Afterwards go to IDLE; cfg_ready returns 1 the following cycle.
// - FrameStrobe is never multi-hot; it is 0 in IDLE and DATA.
// - cfg_valid held high with cfg_ready=0 is not a transfer; the data is accepted later unchanged.
// - Back-to-back frames: a header in the first IDLE cycle after STROBE is accepted. There are no dead cycles beyond STROBE.
// - Latency: last data word accepted at edge t -> FrameStrobe high on cycles t+1 .. t+StrobeCycles.
// TESTING
// - Reset, then header 0xFA000003 + 4 data words D0..D3 (ColumnIndex=0):
//   - FrameData = {D3,D2,D1,D0}.
//   - FrameStrobe = 20'h00008 for 1 cycle, the cycle after D3.
//   - frames_written = 1.
// - Header 0xFA050003 (column 5, no match), 4 words: no strobe, FrameData unchanged, no error, busy back to 0 after the 4th word.
// - Header 0x12000000: err_sync pulses 1 cycle, state stays IDLE. A following good header + 4 words strobes normally.
// - Header 0xFA000014 (idx 20) + 4 words: err_range pulses once, FrameStrobe stays 0, counter unchanged.
// - StrobeCycles=3, cfg_valid held high with the next header queued: cfg_ready=0 for 3 cycles; the header is accepted on cycle 4 with nothing lost.
// - resetn=0 after 2 of 4 data words: everything cleared. A new full frame then strobes correctly, and the old words do not appear in FrameData.
// - Counter preset by 65535 frames (or forced): the next strobe wraps frames_written to 0.

Source files
------------

// File: rtl/column_frame_writer.sv
// Column frame writer: accepts a header word plus NumRows data words from the
// config stream. It assembles them into FrameData and then pulses a single
// FrameStrobe bit for the addressed frame of this column.
module column_frame_writer #(
  parameter int          MaxFramesPerCol = 20,
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumRows         = 4,
  parameter logic [7:0]  ColumnIndex     = 8'd0,
  parameter int          StrobeCycles    = 1
) (
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [FrameBitsPerRow-1:0]           cfg_data,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic                                 err_sync,
  output logic                                 err_range,
  output logic [15:0]                          frames_written
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STROBE = 2'd2
  } state_t;

  state_t                               state_q, state_d;
  logic [RowW-1:0]                      row_q, row_d;
  logic                                 match_q, match_d;
  logic [7:0]                           idx_q, idx_d;
  logic [NumRows*FrameBitsPerRow-1:0]   frame_data_q, frame_data_d;
  logic [MaxFramesPerCol-1:0]           strobe_q, strobe_d;
  logic [3:0]                           scnt_q, scnt_d;
  logic [15:0]                          count_q, count_d;
  logic                                 err_sync_q, err_sync_d;
  logic                                 err_range_q, err_range_d;
  logic                                 xfer;
  logic                                 cfg_unused;

  // Header bits [15:8] carry no meaning for this block.
  assign cfg_unused = ^cfg_data[15:8];

  // Ready depends only on state so a stalled word is simply re-presented.
  assign cfg_ready      = (state_q != STROBE);
  assign xfer           = cfg_valid && cfg_ready;
  assign busy           = (state_q != IDLE);
  assign FrameData      = frame_data_q;
  assign FrameStrobe    = strobe_q;
  assign err_sync       = err_sync_q;
  assign err_range      = err_range_q;
  assign frames_written = count_q;

  // Next-state, frame assembly, strobe timing and error pulses.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    match_d      = match_q;
    idx_d        = idx_q;
    frame_data_d = frame_data_q;
    strobe_d     = strobe_q;
    scnt_d       = scnt_q;
    count_d      = count_q;
    err_sync_d   = 1'b0;
    err_range_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (cfg_data[31:24] != 8'hFA) begin
            err_sync_d = 1'b1;
          end else begin
            match_d = (cfg_data[23:16] == ColumnIndex);
            idx_d   = cfg_data[7:0];
            row_d   = '0;
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (xfer) begin
          // Frames addressed to other columns are consumed but not stored.
          if (match_q) begin
            frame_data_d[row_q*FrameBitsPerRow +: FrameBitsPerRow] = cfg_data;
          end
          row_d = row_q + 1'b1;
          if (row_q == RowW'(NumRows - 1)) begin
            row_d = '0;
            if (match_q && ({24'd0, idx_q} < 32'(MaxFramesPerCol))) begin
              state_d  = STROBE;
              strobe_d = StrobeOne << idx_q;
              scnt_d   = '0;
              count_d  = count_q + 16'd1;
            end else begin
              err_range_d = match_q;
              state_d     = IDLE;
            end
          end
        end
      end

      STROBE: begin
        if (scnt_q == 4'(StrobeCycles - 1)) begin
          state_d  = IDLE;
          strobe_d = '0;
          scnt_d   = '0;
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end

      default: begin
        state_d  = IDLE;
        strobe_d = '0;
      end
    endcase
  end

  // State and datapath registers; reset also discards any partial frame.
  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q      <= IDLE;
      row_q        <= '0;
      match_q      <= 1'b0;
      idx_q        <= '0;
      frame_data_q <= '0;
      strobe_q     <= '0;
      scnt_q       <= '0;
      count_q      <= '0;
      err_sync_q   <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      match_q      <= match_d;
      idx_q        <= idx_d;
      frame_data_q <= frame_data_d;
      strobe_q     <= strobe_d;
      scnt_q       <= scnt_d;
      count_q      <= count_d;
      err_sync_q   <= err_sync_d;
      err_range_q  <= err_range_d;
    end
  end

endmodule

// File: tb/tb_column_frame_writer.sv
// Scoreboard bench for column_frame_writer: expected strobe/error events are
// queued as stimulus is issued and popped by per-instance monitors.
module tb_column_frame_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          v0, r0, busy0, es0, er0;
  logic [31:0]   d0;
  logic [127:0]  fd0;
  logic [19:0]   fs0;
  logic [15:0]   fw0;
  logic          v1, r1, busy1, es1, er1;
  logic [31:0]   d1;
  logic [127:0]  fd1;
  logic [19:0]   fs1;
  logic [15:0]   fw1;

  column_frame_writer #(
    .MaxFramesPerCol(20), .FrameBitsPerRow(32), .NumRows(4),
    .ColumnIndex(8'd0), .StrobeCycles(1)
  ) dut0 (
    .UserCLK(clk), .resetn(resetn), .cfg_valid(v0), .cfg_ready(r0),
    .cfg_data(d0), .FrameData(fd0), .FrameStrobe(fs0), .busy(busy0),
    .err_sync(es0), .err_range(er0), .frames_written(fw0)
  );

  column_frame_writer #(
    .MaxFramesPerCol(20), .FrameBitsPerRow(32), .NumRows(4),
    .ColumnIndex(8'd0), .StrobeCycles(3)
  ) dut1 (
    .UserCLK(clk), .resetn(resetn), .cfg_valid(v1), .cfg_ready(r1),
    .cfg_data(d1), .FrameData(fd1), .FrameStrobe(fs1), .busy(busy1),
    .err_sync(es1), .err_range(er1), .frames_written(fw1)
  );

  typedef struct {
    logic [1:0]   kind;   // 0 strobe, 1 err_sync, 2 err_range
    logic [19:0]  strobe;
    logic [127:0] data;
    logic [15:0]  cnt;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor for instance 0: every strobe cycle or error pulse is one event.
  logic [1:0] k0;
  ev_t        e0;
  always @(negedge clk) begin
    if (resetn === 1'b1 && (fs0 != 20'd0 || es0 || er0)) begin
      k0 = es0 ? 2'd1 : (er0 ? 2'd2 : 2'd0);
      if (q0.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut0_unexpected_event: actual kind=%0d strobe=%0h required none", k0, fs0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_event_kind", 128'(k0), 128'(e0.kind));
        chk("dut0_event_strobe", 128'(fs0), 128'(e0.strobe));
        if (e0.kind == 2'd0) begin
          chk("dut0_event_framedata", fd0, e0.data);
          chk("dut0_event_count", 128'(fw0), 128'(e0.cnt));
        end
      end
      if ($countones(fs0) > 1) chk("dut0_onehot", 128'($countones(fs0)), 128'(1));
    end
  end

  // Monitor for instance 1 (three-cycle strobe).
  logic [1:0] k1;
  ev_t        e1;
  always @(negedge clk) begin
    if (resetn === 1'b1 && (fs1 != 20'd0 || es1 || er1)) begin
      k1 = es1 ? 2'd1 : (er1 ? 2'd2 : 2'd0);
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut1_unexpected_event: actual kind=%0d strobe=%0h required none", k1, fs1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_event_kind", 128'(k1), 128'(e1.kind));
        chk("dut1_event_strobe", 128'(fs1), 128'(e1.strobe));
        chk("dut1_event_framedata", fd1, e1.data);
        chk("dut1_event_count", 128'(fw1), 128'(e1.cnt));
      end
    end
  end

  // Present one word on instance 0 and wait until it is taken.
  task automatic send0(input logic [31:0] w);
    logic acc;
    bit   ok;
    ok = 1'b0;
    v0 = 1'b1;
    d0 = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = r0;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    v0 = 1'b0;
    if (!ok) chk("dut0_send_timeout", 128'(0), 128'(1));
  endtask

  // Present one word on instance 1, keep valid high, report stall cycles.
  task automatic send1(input logic [31:0] w, output int stalls);
    logic acc;
    bit   ok;
    ok     = 1'b0;
    stalls = 0;
    v1     = 1'b1;
    d1     = w;
    for (int i = 0; i < 50 && !ok; i++) begin
      acc = r1;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
      if (acc) ok = 1'b1;
    end
    if (!ok) chk("dut1_send_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    resetn = 1'b0;
    v0 = 1'b0; d0 = '0;
    v1 = 1'b0; d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state
    chk("reset_ready", 128'(r0), 128'(1));
    chk("reset_busy", 128'(busy0), 128'(0));
    chk("reset_framedata", fd0, 128'(0));
    chk("reset_strobe", 128'(fs0), 128'(0));
    chk("reset_count", 128'(fw0), 128'(0));
    chk("reset_errs", 128'({es0, er0}), 128'(0));

    // Frame 3 to column 0
    q0.push_back('{2'd0, 20'h00008,
                   {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 16'd1});
    send0(32'hFA00_0003);
    chk("hdr_busy", 128'(busy0), 128'(1));
    send0(32'hD0D0_0000);
    send0(32'hD1D1_0001);
    send0(32'hD2D2_0002);
    send0(32'hD3D3_0003);
    repeat (2) @(posedge clk);
    #1;
    chk("f1_count", 128'(fw0), 128'(1));
    chk("f1_strobe_off", 128'(fs0), 128'(0));
    chk("f1_idle", 128'(busy0), 128'(0));

    // Frame for column 5: consumed, no effect
    send0(32'hFA05_0003);
    send0(32'h5555_0000);
    send0(32'h5555_0001);
    send0(32'h5555_0002);
    send0(32'h5555_0003);
    chk("nomatch_busy", 128'(busy0), 128'(0));
    chk("nomatch_framedata", fd0,
        {32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000});
    chk("nomatch_count", 128'(fw0), 128'(1));

    // Bad magic, then a good frame 7
    q0.push_back('{2'd1, 20'h0, 128'h0, 16'h0});
    send0(32'h1200_0000);
    chk("badsync_busy", 128'(busy0), 128'(0));
    q0.push_back('{2'd0, 20'h00080,
                   {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 16'd2});
    send0(32'hFA00_0007);
    send0(32'h7777_0000);
    send0(32'h7777_0001);
    send0(32'h7777_0002);
    send0(32'h7777_0003);
    repeat (2) @(posedge clk);
    #1;

    // Frame index 20 is out of range
    q0.push_back('{2'd2, 20'h0, 128'h0, 16'h0});
    send0(32'hFA00_0014);
    send0(32'hEEEE_0000);
    send0(32'hEEEE_0001);
    send0(32'hEEEE_0002);
    send0(32'hEEEE_0003);
    repeat (2) @(posedge clk);
    #1;
    chk("range_count", 128'(fw0), 128'(2));
    chk("range_strobe", 128'(fs0), 128'(0));

    // Reset in the middle of a frame
    send0(32'hFA00_0001);
    send0(32'hBAD0_0000);
    send0(32'hBAD0_0001);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("midreset_framedata", fd0, 128'(0));
    chk("midreset_count", 128'(fw0), 128'(0));
    chk("midreset_busy", 128'(busy0), 128'(0));
    q0.push_back('{2'd0, 20'h80000,
                   {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000}, 16'd1});
    send0(32'hFA00_0013);
    send0(32'hE0E0_0000);
    send0(32'hE1E1_0001);
    send0(32'hE2E2_0002);
    send0(32'hE3E3_0003);
    repeat (2) @(posedge clk);
    #1;
    chk("after_reset_framedata", fd0,
        {32'hE3E3_0003, 32'hE2E2_0002, 32'hE1E1_0001, 32'hE0E0_0000});

    // Counter wrap from 0xFFFF
    force dut0.count_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut0.count_q;
    @(posedge clk);
    #1;
    chk("preset_count", 128'(fw0), 128'(16'hFFFF));
    q0.push_back('{2'd0, 20'h00001,
                   {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000}, 16'h0000});
    send0(32'hFA00_0000);
    send0(32'hF0F0_0000);
    send0(32'hF1F1_0001);
    send0(32'hF2F2_0002);
    send0(32'hF3F3_0003);
    repeat (2) @(posedge clk);
    #1;
    chk("wrap_count", 128'(fw0), 128'(0));

    // Three-cycle strobe with the next header waiting on a held valid
    repeat (3) q1.push_back('{2'd0, 20'h00004,
                              {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000}, 16'd1});
    repeat (3) q1.push_back('{2'd0, 20'h00010,
                              {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000}, 16'd2});
    send1(32'hFA00_0002, st);
    send1(32'hA0A0_0000, st);
    send1(32'hA1A1_0001, st);
    send1(32'hA2A2_0002, st);
    send1(32'hA3A3_0003, st);
    send1(32'hFA00_0004, st);
    chk("b2b_stall_cycles", 128'(st), 128'(3));
    send1(32'hB0B0_0000, st);
    chk("b2b_first_word_stall", 128'(st), 128'(0));
    send1(32'hB1B1_0001, st);
    send1(32'hB2B2_0002, st);
    send1(32'hB3B3_0003, st);
    v1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("b2b_count", 128'(fw1), 128'(2));

    chk("dut0_events_outstanding", 128'(q0.size()), 128'(0));
    chk("dut1_events_outstanding", 128'(q1.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
